// File: rtl/ttm4_sequencer.sv
// Fetch/decode/execute sequencer for the TTM4 4-bit core: registered active-low strobes for the register stage.
// Optional trap on undefined opcodes 0xB..0xE via the TTM4_ILLEGAL_TRAP_EN macro.
module ttm4_sequencer #(
    parameter int FETCH_WAIT = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN,
    input  logic [7:0] INST,
    input  logic       CF,
    output logic       nPC_LD,
    output logic       nPC_OPEN,
    output logic       nJRD_ST,
    output logic       nJRU_ST,
    output logic       nORD_ST,
    output logic       nORU_ST,
    output logic       nJRD_OUT,
    output logic       nJRU_OUT,
    output logic       nIRD_OUT,
    output logic       nIRU_OUT,
    output logic [3:0] IMM,
    output logic       nIMM_OE,
    output logic       nA_LD,
    output logic       HALTED,
    output logic       ILLEGAL
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

    // Active-low strobe bundle; all ones means idle.
    typedef struct packed {
        logic pc_ld;
        logic pc_open;
        logic jrd_st;
        logic jru_st;
        logic ord_st;
        logic oru_st;
        logic jrd_out;
        logic jru_out;
        logic ird_out;
        logic iru_out;
        logic imm_oe;
        logic a_ld;
    } strobe_t;

    localparam strobe_t    STB_IDLE = '1;
    localparam logic [1:0] WAIT_MAX = 2'(FETCH_WAIT);

    state_t     state, state_n;
    logic [1:0] wait_cnt, wait_n;
    logic [7:0] ir, ir_n;
    logic [3:0] imm_n;
    strobe_t    stb, stb_n;
    logic       halted_n;
    logic       trap;

    function automatic logic is_ldi(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h4);
    endfunction

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n  = state;
        wait_n   = wait_cnt;
        ir_n     = ir;
        imm_n    = IMM;
        stb_n    = STB_IDLE;
        halted_n = HALTED;
        trap     = 1'b0;
        case (state)
            FETCH: begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_n = wait_cnt + 2'd1;
                end else if (RUN) begin
                    state_n      = DECODE;
                    ir_n         = INST;
                    imm_n        = INST[3:0];
                    stb_n.imm_oe = !is_ldi(INST[7:4]);
                end
            end
            DECODE: begin
                state_n      = EXEC;
                stb_n.imm_oe = !is_ldi(ir[7:4]);
                case (ir[7:4])
                    4'h0: stb_n.pc_open = 1'b0;
                    4'h1: begin stb_n.jrd_st = 1'b0; stb_n.pc_open = 1'b0; end
                    4'h2: begin stb_n.jru_st = 1'b0; stb_n.pc_open = 1'b0; end
                    4'h3: begin stb_n.ord_st = 1'b0; stb_n.pc_open = 1'b0; end
                    4'h4: begin stb_n.oru_st = 1'b0; stb_n.pc_open = 1'b0; end
                    4'h5: stb_n.pc_ld = 1'b0;
                    4'h6: begin
                        if (CF) stb_n.pc_open = 1'b0;
                        else    stb_n.pc_ld   = 1'b0;
                    end
                    4'h7: begin stb_n.ird_out = 1'b0; stb_n.a_ld = 1'b0; stb_n.pc_open = 1'b0; end
                    4'h8: begin stb_n.iru_out = 1'b0; stb_n.a_ld = 1'b0; stb_n.pc_open = 1'b0; end
                    4'h9: begin stb_n.jrd_out = 1'b0; stb_n.a_ld = 1'b0; stb_n.pc_open = 1'b0; end
                    4'hA: begin stb_n.jru_out = 1'b0; stb_n.a_ld = 1'b0; stb_n.pc_open = 1'b0; end
                    4'hF: begin state_n = HALT; halted_n = 1'b1; end
                    default: begin
`ifdef TTM4_ILLEGAL_TRAP_EN
                        state_n  = HALT;
                        halted_n = 1'b1;
                        trap     = 1'b1;
`else
                        stb_n.pc_open = 1'b0;
`endif
                    end
                endcase
            end
            EXEC: begin
                state_n = FETCH;
                wait_n  = 2'd0;
            end
            HALT: state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= FETCH;
            wait_cnt <= 2'd0;
            ir       <= 8'h00;
            IMM      <= 4'h0;
            stb      <= STB_IDLE;
            HALTED   <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            ir       <= ir_n;
            IMM      <= imm_n;
            stb      <= stb_n;
            HALTED   <= halted_n;
        end
    end

`ifdef TTM4_ILLEGAL_TRAP_EN
    always_ff @(posedge CLK) begin
        if (!RST)      ILLEGAL <= 1'b0;
        else if (trap) ILLEGAL <= 1'b1;
    end
`else
    assign ILLEGAL = 1'b0;
`endif

    assign nPC_LD   = stb.pc_ld;
    assign nPC_OPEN = stb.pc_open;
    assign nJRD_ST  = stb.jrd_st;
    assign nJRU_ST  = stb.jru_st;
    assign nORD_ST  = stb.ord_st;
    assign nORU_ST  = stb.oru_st;
    assign nJRD_OUT = stb.jrd_out;
    assign nJRU_OUT = stb.jru_out;
    assign nIRD_OUT = stb.ird_out;
    assign nIRU_OUT = stb.iru_out;
    assign nIMM_OE  = stb.imm_oe;
    assign nA_LD    = stb.a_ld;

    // Bus-contention and sequencing invariants on the registered strobes.
    a_one_store: assert property (@(posedge CLK) disable iff (!RST)
        $onehot0(~{nJRD_ST, nJRU_ST, nORD_ST, nORU_ST}));
    a_one_out: assert property (@(posedge CLK) disable iff (!RST)
        $onehot0(~{nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT}));
    a_pc_excl: assert property (@(posedge CLK) disable iff (!RST)
        !(!nPC_LD && !nPC_OPEN));
    a_exec_only: assert property (@(posedge CLK) disable iff (!RST)
        (state != EXEC) |-> (&{stb.pc_ld, stb.pc_open, stb.jrd_st, stb.jru_st, stb.ord_st, stb.oru_st,
                               stb.jrd_out, stb.jru_out, stb.ird_out, stb.iru_out, stb.a_ld}));

endmodule

// File: tb/tb_ttm4_sequencer.sv
// Directed bench for ttm4_sequencer: FETCH_WAIT=0 instance for opcodes/halt/reset, FETCH_WAIT=2 instance for wait states.
module tb_ttm4_sequencer;

    logic       CLK = 1'b0;
    logic       RST, RUN, CF;
    logic [7:0] INST;
    logic       nPC_LD, nPC_OPEN, nJRD_ST, nJRU_ST, nORD_ST, nORU_ST;
    logic       nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT, nIMM_OE, nA_LD;
    logic [3:0] IMM;
    logic       HALTED, ILLEGAL;

    logic       rst_w, run_w;
    logic [7:0] inst_w;
    logic       w_pc_ld, w_pc_open, w_jrd_st, w_jru_st, w_ord_st, w_oru_st;
    logic       w_jrd_out, w_jru_out, w_ird_out, w_iru_out, w_imm_oe, w_a_ld;
    logic [3:0] w_imm;
    logic       w_halted, w_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ttm4_sequencer #(.FETCH_WAIT(0)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .INST(INST), .CF(CF),
        .nPC_LD(nPC_LD), .nPC_OPEN(nPC_OPEN),
        .nJRD_ST(nJRD_ST), .nJRU_ST(nJRU_ST), .nORD_ST(nORD_ST), .nORU_ST(nORU_ST),
        .nJRD_OUT(nJRD_OUT), .nJRU_OUT(nJRU_OUT), .nIRD_OUT(nIRD_OUT), .nIRU_OUT(nIRU_OUT),
        .IMM(IMM), .nIMM_OE(nIMM_OE), .nA_LD(nA_LD), .HALTED(HALTED), .ILLEGAL(ILLEGAL)
    );

    ttm4_sequencer #(.FETCH_WAIT(2)) dut_w (
        .CLK(CLK), .RST(rst_w), .RUN(run_w), .INST(inst_w), .CF(CF),
        .nPC_LD(w_pc_ld), .nPC_OPEN(w_pc_open),
        .nJRD_ST(w_jrd_st), .nJRU_ST(w_jru_st), .nORD_ST(w_ord_st), .nORU_ST(w_oru_st),
        .nJRD_OUT(w_jrd_out), .nJRU_OUT(w_jru_out), .nIRD_OUT(w_ird_out), .nIRU_OUT(w_iru_out),
        .IMM(w_imm), .nIMM_OE(w_imm_oe), .nA_LD(w_a_ld), .HALTED(w_halted), .ILLEGAL(w_illegal)
    );

    // Bit order: pc_ld pc_open jrd_st jru_st ord_st oru_st jrd_out jru_out ird_out iru_out imm_oe a_ld
    logic [11:0] stb, stb_w;
    assign stb   = {nPC_LD, nPC_OPEN, nJRD_ST, nJRU_ST, nORD_ST, nORU_ST,
                    nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT, nIMM_OE, nA_LD};
    assign stb_w = {w_pc_ld, w_pc_open, w_jrd_st, w_jru_st, w_ord_st, w_oru_st,
                    w_jrd_out, w_jru_out, w_ird_out, w_iru_out, w_imm_oe, w_a_ld};

    localparam logic [11:0] IDLE     = 12'hFFF;
    localparam logic [11:0] IMM_ONLY = 12'hFFD;
    localparam logic [11:0] OPEN     = 12'hBFF;
    localparam logic [11:0] PCLD     = 12'h7FF;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH cycle.
    task automatic run_instr(input string tag, input logic [7:0] inst, input logic cf,
                             input logic [11:0] exp_dec, input logic [11:0] exp_exec);
        INST = inst;
        CF   = cf;
        @(negedge CLK);
        check({tag, "/decode"}, 16'(stb), 16'(exp_dec));
        @(negedge CLK);
        check({tag, "/exec"}, 16'(stb), 16'(exp_exec));
        check({tag, "/imm"}, 16'(IMM), 16'(inst[3:0]));
        @(negedge CLK);
        check({tag, "/fetch"}, 16'(stb), 16'(IDLE));
    endtask

    initial begin
        RST = 1'b0; RUN = 1'b0; CF = 1'b0; INST = 8'h13;
        rst_w = 1'b0; run_w = 1'b0; inst_w = 8'h00;

        // Reset and idle with RUN low
        repeat (2) @(negedge CLK);
        check("rst/strobes", 16'(stb), 16'(IDLE));
        check("rst/halted", 16'(HALTED), 16'd0);
        check("rst/illegal", 16'(ILLEGAL), 16'd0);
        check("rst/imm", 16'(IMM), 16'd0);
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("idle/strobes", 16'(stb), 16'(IDLE));
        end
        check("idle/halted", 16'(HALTED), 16'd0);

        // JP nibble loads: DECODE drives nIMM_OE, EXEC adds store and PC advance
        RUN = 1'b1;
        run_instr("jrd_ldi", 8'h1A, 1'b0, IMM_ONLY, 12'h9FD);
        run_instr("jru_ldi", 8'h25, 1'b0, IMM_ONLY, 12'hAFD);
        run_instr("ord_ldi", 8'h37, 1'b0, IMM_ONLY, 12'hB7D);
        run_instr("oru_ldi", 8'h4C, 1'b0, IMM_ONLY, 12'hBBD);

        // Jumps and NOP
        run_instr("nop", 8'h00, 1'b0, IDLE, OPEN);
        run_instr("jmp", 8'h50, 1'b1, IDLE, PCLD);
        run_instr("jnc_cf0", 8'h60, 1'b0, IDLE, PCLD);
        run_instr("jnc_cf1", 8'h60, 1'b1, IDLE, OPEN);

        // Loadbus transfers into the accumulator
        run_instr("lda_ird", 8'h70, 1'b0, IDLE, 12'hBF6);
        run_instr("lda_iru", 8'h80, 1'b0, IDLE, 12'hBFA);
        run_instr("lda_jrd", 8'h90, 1'b0, IDLE, 12'hBDE);
        run_instr("lda_jru", 8'hA0, 1'b0, IDLE, 12'hBEE);
        check("run/illegal", 16'(ILLEGAL), 16'd0);

        // RUN dropping after fetch still completes the instruction
        INST = 8'h1B;
        @(negedge CLK);
        RUN = 1'b0;
        check("rundrop/decode", 16'(stb), 16'(IMM_ONLY));
        @(negedge CLK);
        check("rundrop/exec", 16'(stb), 16'(12'h9FD));
        @(negedge CLK);
        check("rundrop/fetch", 16'(stb), 16'(IDLE));
        @(negedge CLK);
        check("rundrop/hold", 16'(stb), 16'(IDLE));
        RUN = 1'b1;

        // HLT is absorbing
        INST = 8'hF0;
        @(negedge CLK);
        check("hlt/decode", 16'(stb), 16'(IDLE));
        @(negedge CLK);
        check("hlt/halted", 16'(HALTED), 16'd1);
        for (int i = 0; i < 10; i++) begin
            INST = 8'h10 + 8'(i);
            RUN  = i[0];
            @(negedge CLK);
            check("hlt/strobes", 16'(stb), 16'(IDLE));
            check("hlt/stay", 16'(HALTED), 16'd1);
        end
        RST = 1'b0;
        @(negedge CLK);
        check("hlt/rst_halted", 16'(HALTED), 16'd0);
        RST = 1'b1;
        RUN = 1'b1;

        // Reset during EXEC of ORD_LDI abandons the store
        INST = 8'h30;
        @(negedge CLK);
        check("midrst/decode", 16'(stb), 16'(IMM_ONLY));
        @(negedge CLK);
        check("midrst/exec", 16'(stb), 16'(12'hB7D));
        RST = 1'b0;
        @(negedge CLK);
        check("midrst/strobes", 16'(stb), 16'(IDLE));
        check("midrst/nord_st", 16'(nORD_ST), 16'd1);
        RST = 1'b1;
        run_instr("restart", 8'h30, 1'b0, IMM_ONLY, 12'hB7D);

        // Undefined opcode
        INST = 8'hC0;
        @(negedge CLK);
        check("undef/decode", 16'(stb), 16'(IDLE));
        @(negedge CLK);
`ifdef TTM4_ILLEGAL_TRAP_EN
        check("undef/strobes", 16'(stb), 16'(IDLE));
        check("undef/illegal", 16'(ILLEGAL), 16'd1);
        check("undef/halted", 16'(HALTED), 16'd1);
        INST = 8'h00;
        @(negedge CLK);
        check("undef/stay", 16'(stb), 16'(IDLE));
        check("undef/illegal_hold", 16'(ILLEGAL), 16'd1);
`else
        check("undef/strobes", 16'(stb), 16'(OPEN));
        check("undef/illegal", 16'(ILLEGAL), 16'd0);
        check("undef/halted", 16'(HALTED), 16'd0);
`endif

        // FETCH_WAIT=2: one EXEC every five cycles
        rst_w  = 1'b1;
        run_w  = 1'b1;
        inst_w = 8'h05;
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLK);
            check("wait/strobes", 16'(stb_w), 16'((k % 5 == 4) ? OPEN : IDLE));
        end
        check("wait/imm", 16'(w_imm), 16'd5);
        check("wait/flags", 16'({w_halted, w_illegal}), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
